// File: rtl/timeout_timer_ctrl.sv
// Timeout timer plus M-button conditioner for the supervisory fsm.
// m_raw is synchronized and debounced into m_level/m_pulse; the fsm steers the down-counter that raises t0.
module timeout_timer_ctrl #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 50,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_raw,
    input  logic             en_cont,
    input  logic             rst_timer,
    output logic             m_pulse,
    output logic             m_level,
    output logic             t0,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    // state   | meaning
    // IDLE    | counter cleared, waiting for en_cont
    // RUN     | counting down once per enabled cycle
    // PAUSE   | en_cont dropped, count frozen
    // EXPIRED | timeout reached, t0 held until rst_timer
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    if ((TIMEOUT < 1) || (longint'(TIMEOUT) > (longint'(1) << CNT_W))) begin : g_bad_timeout
        $error("timeout_timer_ctrl: TIMEOUT must lie in 1..2**CNT_W");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("timeout_timer_ctrl: DEB_CYCLES must be >= 1");
    end

    logic             m_meta;
    logic             m_sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             m_level_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_meta <= 1'b0;
            m_sync <= 1'b0;
        end else begin
            m_meta <= m_raw;
            m_sync <= m_meta;
        end
    end

    // The counter measures how long m_sync has disagreed with the accepted level.
    always_comb begin
        m_level_nx = m_level;
        if ((m_sync != m_level) && (deb_cnt == DEB_LAST)) begin
            m_level_nx = m_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt <= '0;
            m_level <= 1'b0;
            m_pulse <= 1'b0;
        end else begin
            if ((m_sync == m_level) || (deb_cnt == DEB_LAST)) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            m_level <= m_level_nx;
            m_pulse <= m_level_nx & ~m_level;
        end
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] count_nx;
    logic             t0_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            t0    <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            t0    <= t0_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        t0_nx    = t0;
        if (rst_timer) begin
            state_nx = IDLE;
            count_nx = '0;
            t0_nx    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    count_nx = '0;
                    t0_nx    = 1'b0;
                    if (en_cont) begin
                        state_nx = RUN;
                        count_nx = LOAD_VAL;
                    end
                end
                RUN: begin
                    if (!en_cont) begin
                        state_nx = PAUSE;
                    end else if (count != '0) begin
                        count_nx = count - 1'b1;
                    end else begin
                        state_nx = EXPIRED;
                        t0_nx    = 1'b1;
                    end
                end
                // Resuming spends one edge returning to RUN without decrementing.
                PAUSE: begin
                    if (en_cont) begin
                        state_nx = RUN;
                    end
                end
                EXPIRED: begin
                    count_nx = '0;
                    t0_nx    = 1'b1;
                end
                default: begin
                    state_nx = IDLE;
                    count_nx = '0;
                    t0_nx    = 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == RUN) || (state == PAUSE);

endmodule

// File: tb/tb_timeout_timer_ctrl.sv
// Directed bench for timeout_timer_ctrl with TIMEOUT=5, DEB_CYCLES=4.
// Outputs are sampled 1 ns after each rising edge; inputs change at that point too.
module tb_timeout_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_raw;
    logic        en_cont;
    logic        rst_timer;
    logic        m_pulse;
    logic        m_level;
    logic        t0;
    logic [15:0] count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    timeout_timer_ctrl #(
        .CNT_W      (16),
        .TIMEOUT    (5),
        .DEB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_raw     (m_raw),
        .en_cont   (en_cont),
        .rst_timer (rst_timer),
        .m_pulse   (m_pulse),
        .m_level   (m_level),
        .t0        (t0),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        m_raw     = 1'b1;
        en_cont   = 1'b1;
        rst_timer = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({m_pulse, m_level, t0, busy} !== 4'b0000 || count !== 16'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: pulse=%b level=%b t0=%b busy=%b count=%0d, required all 0",
                         i, m_pulse, m_level, t0, busy, count);
            end
            if (i < 2) tick();
        end
        m_raw   = 1'b0;
        en_cont = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || count !== 16'd0 || t0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b count=%0d t0=%b, required 0/0/0", busy, count, t0);
        end
    endtask

    task automatic clear_timer();
        rst_timer = 1'b1;
        en_cont   = 1'b0;
        tick();
        rst_timer = 1'b0;
    endtask

    task automatic test_count();
        logic [15:0] exp_cnt;
        en_cont = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_cnt = 16'(4 - i);
            checks++;
            if (count !== exp_cnt || busy !== 1'b1 || t0 !== 1'b0) begin
                errors++;
                $display("FAIL count_E%0d: count=%0d busy=%b t0=%b, required count=%0d busy=1 t0=0",
                         i, count, busy, t0, exp_cnt);
            end
        end
        tick();
        checks++;
        if (t0 !== 1'b1 || busy !== 1'b0 || count !== 16'd0) begin
            errors++;
            $display("FAIL count_expiry_E5: t0=%b busy=%b count=%0d, required t0=1 busy=0 count=0", t0, busy, count);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (t0 !== 1'b1 || count !== 16'd0) begin
                errors++;
                $display("FAIL count_t0_hold %0d: t0=%b count=%0d, required t0=1 count=0", i, t0, count);
            end
        end
        clear_timer();
    endtask

    task automatic test_pause();
        logic [15:0] exp_cnt;
        en_cont = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (count !== 16'd2) begin
            errors++;
            $display("FAIL pause_setup: count=%0d, required 2", count);
        end
        en_cont = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 16'd2 || busy !== 1'b1 || t0 !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold %0d: count=%0d busy=%b t0=%b, required 2/1/0", i, count, busy, t0);
            end
        end
        en_cont = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_cnt = 16'(2 - i);
            checks++;
            if (count !== exp_cnt || t0 !== 1'b0) begin
                errors++;
                $display("FAIL pause_resume E%0d: count=%0d t0=%b, required count=%0d t0=0",
                         6 + i, count, t0, exp_cnt);
            end
        end
        tick();
        checks++;
        if (t0 !== 1'b1) begin
            errors++;
            $display("FAIL pause_expiry_E9: t0=%b, required 1", t0);
        end
        clear_timer();
    endtask

    task automatic test_clear();
        en_cont = 1'b1;
        repeat (6) tick();
        checks++;
        if (t0 !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup_expired: t0=%b, required 1", t0);
        end
        rst_timer = 1'b1;
        tick();
        checks++;
        if (t0 !== 1'b0 || count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_expired: t0=%b count=%0d busy=%b, required 0/0/0", t0, count, busy);
        end
        rst_timer = 1'b0;
        tick();
        tick();
        checks++;
        if (count !== 16'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup_run: count=%0d busy=%b, required 3/1", count, busy);
        end
        rst_timer = 1'b1;
        tick();
        checks++;
        if (t0 !== 1'b0 || count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid_run: t0=%b count=%0d busy=%b, required 0/0/0", t0, count, busy);
        end
        rst_timer = 1'b0;
        repeat (5) tick();
        checks++;
        if (count !== 16'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup_zero: count=%0d busy=%b, required 0/1", count, busy);
        end
        rst_timer = 1'b1;
        tick();
        checks++;
        if (t0 !== 1'b0 || busy !== 1'b0 || count !== 16'd0) begin
            errors++;
            $display("FAIL clear_vs_expiry: t0=%b busy=%b count=%0d, required 0/0/0", t0, busy, count);
        end
        rst_timer = 1'b0;
        en_cont   = 1'b0;
        tick();
    endtask

    task automatic test_debounce();
        int pulses;
        m_raw = 1'b1;
        tick();
        tick();
        m_raw = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_pulse === 1'b1) pulses++;
            checks++;
            if (m_level !== 1'b0) begin
                errors++;
                $display("FAIL debounce_glitch_level %0d: m_level=%b, required 0", i, m_level);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL debounce_glitch_pulse: pulses=%0d, required 0", pulses);
        end
        m_raw = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) m_raw = 1'b0;
            if (m_pulse === 1'b1) pulses++;
            checks++;
            if (m_pulse !== (i == 6) || m_level !== (i >= 6 && i < 16)) begin
                errors++;
                $display("FAIL debounce_stable cycle %0d: m_pulse=%b m_level=%b, required %b %b",
                         i, m_pulse, m_level, (i == 6), (i >= 6 && i < 16));
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL debounce_pulse_count: pulses=%0d, required 1", pulses);
        end
    endtask

    task automatic test_async_reset();
        en_cont = 1'b1;
        repeat (3) tick();
        checks++;
        if (count !== 16'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: count=%0d busy=%b, required 2/1", count, busy);
        end
        #2;
        rst     = 1'b0;
        en_cont = 1'b0;
        #1;
        checks++;
        if (count !== 16'd0 || busy !== 1'b0 || t0 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: count=%0d busy=%b t0=%b, required 0/0/0", count, busy, t0);
        end
        #3;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (t0 !== 1'b0 || busy !== 1'b0 || count !== 16'd0) begin
                errors++;
                $display("FAIL async_no_late_t0 %0d: t0=%b busy=%b count=%0d, required 0/0/0", i, t0, busy, count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_pause();
        test_clear();
        test_debounce();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
